// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared RV32I load/store constants, LSU state type and request legality check
package processor_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_RD,
    LSU_CAPTURE,
    LSU_MERGE,
    LSU_WR,
    LSU_RESP,
    LSU_ERR
  } lsu_state_t;

  // True when the request must be rejected without touching memory.
  function automatic logic lsu_req_error(input logic       is_load,
                                         input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] byte_off);
    logic err;
    err = 1'b0;
    if (is_load == is_store) begin
      err = 1'b1;
    end else if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = byte_off[0];
        F3_LW:         err = |byte_off;
        default:       err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = byte_off[0];
        F3_SW:   err = |byte_off;
        default: err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian load extract/extend and sub-word store merge
module lsu_byte_lane
  import processor_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'h00;
    case (byte_off)
      2'd0: lane_byte = rd_word[7:0];
      2'd1: lane_byte = rd_word[15:8];
      2'd2: lane_byte = rd_word[23:16];
      2'd3: lane_byte = rd_word[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = rd_word;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_data = rd_word;
      F3_LBU:  load_data = {24'h000000, lane_byte};
      F3_LHU:  load_data = {16'h0000, lane_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    case (funct3)
      F3_SB: begin
        case (byte_off)
          2'd0: merged_word[7:0]   = store_data[7:0];
          2'd1: merged_word[15:8]  = store_data[7:0];
          2'd2: merged_word[23:16] = store_data[7:0];
          2'd3: merged_word[31:24] = store_data[7:0];
          default: merged_word = rd_word;
        endcase
      end
      F3_SH: begin
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-access stage on a word-wide BRAM without byte enables
module load_store_unit
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_base,
  input  logic [31:0]           req_offset,
  input  logic [31:0]           req_store_data,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_load_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  lsu_state_t state_q, state_d;

  logic [31:0]           addr;
  logic                  req_err;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_addr_q;
  logic [1:0]            byte_off_q;
  logic [2:0]            funct3_q;
  logic                  is_load_q;
  logic [31:0]           store_data_q;
  logic [31:0]           wbuf_q;
  logic [31:0]           load_data_q;
  logic [31:0]           lane_load;
  logic [31:0]           lane_merged;

  assign addr    = req_base + req_offset;
  assign req_err = lsu_req_error(req_is_load, req_is_store, req_funct3, addr[1:0]);
  assign accept  = (state_q == LSU_IDLE) && req_valid;

  lsu_byte_lane u_byte_lane (
    .funct3      (funct3_q),
    .byte_off    (byte_off_q),
    .rd_word     (mem_read_data),
    .store_data  (store_data_q),
    .load_data   (lane_load),
    .merged_word (lane_merged)
  );

  // wbuf_q preloads the store data so a full-word store can write it directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= LSU_IDLE;
      word_addr_q  <= '0;
      byte_off_q   <= 2'b00;
      funct3_q     <= 3'b000;
      is_load_q    <= 1'b0;
      store_data_q <= 32'h0;
      wbuf_q       <= 32'h0;
      load_data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_addr_q  <= addr[ADDR_WIDTH+1:2];
        byte_off_q   <= addr[1:0];
        funct3_q     <= req_funct3;
        is_load_q    <= req_is_load;
        store_data_q <= req_store_data;
        wbuf_q       <= req_store_data;
      end
      if (state_q == LSU_CAPTURE) load_data_q <= lane_load;
      if (state_q == LSU_MERGE)   wbuf_q      <= lane_merged;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    mem_addr         = word_addr_q;
    case (state_q)
      LSU_IDLE: begin
        req_ready = 1'b1;
        mem_addr  = '0;
        if (req_valid) begin
          if (req_err)                                   state_d = LSU_ERR;
          else if (req_is_store && req_funct3 == F3_SW)  state_d = LSU_WR;
          else                                           state_d = LSU_RD;
        end
      end
      LSU_RD: begin
        mem_read_enable = 1'b1;
        state_d = is_load_q ? LSU_CAPTURE : LSU_MERGE;
      end
      LSU_CAPTURE: state_d = LSU_RESP;
      LSU_MERGE:   state_d = LSU_WR;
      LSU_WR: begin
        mem_write_enable = 1'b1;
        mem_write_data   = wbuf_q;
        state_d          = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        state_d    = LSU_IDLE;
      end
      LSU_ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
        state_d    = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign resp_load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural BRAM
module tb_load_store_unit;

  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_load = 1'b0;
  logic          req_is_store = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_base = 32'h0;
  logic [31:0]   req_offset = 32'h0;
  logic [31:0]   req_store_data = 32'h0;
  logic          resp_valid;
  logic          resp_error;
  logic [31:0]   resp_load_data;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = 32'h0;

  logic [31:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  time  accept_time = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   wr_cyc = -1;
  int   wr_addr = -1;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_load      (req_is_load),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_base         (req_base),
    .req_offset       (req_offset),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_load_data   (resp_load_data),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_addr] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int cur_cycle();
    return int'(($time - 5 - accept_time) / 10) + 1;
  endfunction

  // Monitor: strobe bookkeeping and scoreboard pops on every response pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_read_enable && mem_write_enable) chk("strobe_overlap", 32'd1, 32'd0);
      if (mem_read_enable) rd_cnt++;
      if (mem_write_enable) begin
        wr_cnt++;
        wr_cyc  = cur_cycle();
        wr_addr = int'(mem_addr);
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, "_err"}, {31'd0, resp_error}, {31'd0, e.err});
          chk({e.name, "_data"}, resp_load_data, e.data);
          chk({e.name, "_lat"}, cur_cycle(), e.lat);
        end
      end
    end
  end

  task automatic do_req(input string name, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                        input logic exp_err, input logic [31:0] exp_data, input int exp_lat,
                        input int exp_rd, input int exp_wr, input int exp_wr_cyc, input int exp_wr_addr);
    exp_t e;
    @(negedge clock);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_store_data = sd;
    req_valid = 1'b1;
    e.err = exp_err; e.data = exp_data; e.lat = exp_lat; e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    accept_time = $time;
    rd_cnt = 0; wr_cnt = 0; wr_cyc = -1; wr_addr = -1;
    #1 req_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      sb_q.delete();
    end
    chk({name, "_reads"}, rd_cnt, exp_rd);
    chk({name, "_writes"}, wr_cnt, exp_wr);
    if (exp_wr_cyc >= 0) begin
      chk({name, "_wr_cycle"}, wr_cyc, exp_wr_cyc);
      chk({name, "_wr_addr"}, wr_addr, exp_wr_addr);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_strobes"}, {29'd0, resp_valid, mem_read_enable, mem_write_enable}, 32'd0);
    chk({name, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    chk({name, "_load_data"}, resp_load_data, 32'd0);
    chk({name, "_mem_addr"}, {25'd0, mem_addr}, 32'd0);
    chk({name, "_wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[3] = 32'h8899AABB;
    mem[4] = 32'h11223344;
    repeat (2) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b1;

    do_req("lb",   1, 0, 3'd0, 32'h0C, 32'h1, 32'h0, 0, 32'hFFFFFFAA, 3, 1, 0, -1, 0);
    do_req("lhu",  1, 0, 3'd5, 32'h0E, 32'h0, 32'h0, 0, 32'h00008899, 3, 1, 0, -1, 0);
    do_req("lh",   1, 0, 3'd1, 32'h0E, 32'h0, 32'h0, 0, 32'hFFFF8899, 3, 1, 0, -1, 0);
    do_req("lw",   1, 0, 3'd2, 32'h0C, 32'h0, 32'h0, 0, 32'h8899AABB, 3, 1, 0, -1, 0);
    do_req("sb",   0, 1, 3'd0, 32'h0F, 32'h0, 32'h12345677, 0, 32'h8899AABB, 4, 1, 1, 3, 3);
    chk("sb_mem3", mem[3], 32'h7799AABB);
    do_req("sw",   0, 1, 3'd2, 32'h10, 32'hFFFFFFFC, 32'hDEADBEEF, 0, 32'h8899AABB, 2, 0, 1, 1, 3);
    chk("sw_mem3", mem[3], 32'hDEADBEEF);
    do_req("lw2",  1, 0, 3'd2, 32'h0C, 32'h0, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, -1, 0);

    do_req("e_lw_mis",  1, 0, 3'd2, 32'h0C, 32'h2, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_sh_mis",  0, 1, 3'd1, 32'h0D, 32'h0, 32'hFFFF, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_f3_ld",   1, 0, 3'd3, 32'h0C, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_both",    1, 1, 3'd2, 32'h0C, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_none",    0, 0, 3'd2, 32'h0C, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_lhu_mis", 1, 0, 3'd5, 32'h0D, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    do_req("e_f3_st",   0, 1, 3'd4, 32'h0C, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, -1, 0);
    chk("err_mem3", mem[3], 32'hDEADBEEF);

    do_req("lbu",  1, 0, 3'd4, 32'h0D, 32'h0, 32'h0, 0, 32'h000000BE, 3, 1, 0, -1, 0);
    do_req("sh",   0, 1, 3'd1, 32'h12, 32'h0, 32'h1234ABCD, 0, 32'h000000BE, 4, 1, 1, 3, 4);
    chk("sh_mem4", mem[4], 32'hABCD3344);
    do_req("lw_wrap", 1, 0, 3'd2, 32'h200, 32'h10, 32'h0, 0, 32'hABCD3344, 3, 1, 0, -1, 0);
    do_req("sb0",  0, 1, 3'd0, 32'h10, 32'h0, 32'h000000FF, 0, 32'hABCD3344, 4, 1, 1, 3, 4);
    chk("sb0_mem4", mem[4], 32'hABCD33FF);
    do_req("lb3",  1, 0, 3'd0, 32'h13, 32'h0, 32'h0, 0, 32'hFFFFFFAB, 3, 1, 0, -1, 0);

    // Abort an SH during MERGE; the halfword must never reach memory.
    @(negedge clock);
    req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = 3'd1;
    req_base = 32'h0E; req_offset = 32'h0; req_store_data = 32'h5555CAFE;
    req_valid = 1'b1;
    @(posedge clock);
    accept_time = $time;
    rd_cnt = 0; wr_cnt = 0;
    #1 req_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk_idle_outputs("abort");
    @(negedge clock);
    chk_idle_outputs("abort_hold");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_writes", wr_cnt, 0);
    chk("abort_mem3", mem[3], 32'hDEADBEEF);
    chk("abort_no_resp", sb_q.size(), 0);

    do_req("lw_post", 1, 0, 3'd2, 32'h0C, 32'h0, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, -1, 0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage for the multi-cycle RV32I core. It sits between the EXECUTE and WRITE_BACK states of the processor FSM. It takes a load or store request (base, offset, store data, funct3), performs the access on a single-port, word-wide BRAM with no byte enables, and returns sign- or zero-extended load data or a completion/error pulse. Sub-word stores are done as read-modify-write.

## Interface
- ADDR_WIDTH, 7, word-index width of the data memory (depth = 2**ADDR_WIDTH words)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  unit idle and able to accept a request
- req_is_load  in  1  request is a load
- req_is_store  in  1  request is a store
- req_funct3  in  3  RV32I load/store funct3
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate (Iimm for loads, Simm for stores)
- req_store_data  in  32  rs2 value
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  qualifies resp_valid: misaligned or illegal request, no memory access made
- resp_load_data  out  32  extended load result; holds until the next accepted request
- mem_addr  out  ADDR_WIDTH  word address
- mem_read_enable  out  1  BRAM read strobe; data valid on mem_read_data the following cycle
- mem_write_enable  out  1  BRAM full-word write strobe
- mem_write_data  out  32  word to write
- mem_read_data  in  32  BRAM read data

## Operation
- Byte address is req_base + req_offset, modulo 2**32. mem_addr = addr[ADDR_WIDTH+1:2]. Higher bits are ignored, so accesses wrap.
- Legal loads: LB=0, LH=1, LW=2, LBU=4, LHU=5. Legal stores: SB=0, SH=1, SW=2.
- A request is an error when any of these hold:
  - funct3 is illegal for the access type.
  - is_load equals is_store.
  - A halfword access has addr[0]≠0.
  - A word access has addr[1:0]≠0.
- Little-endian: byte lane k = word[8k+7:8k], where k = addr[1:0]. Halfword lane = addr[1].
- Loads: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Sub-word stores read the word, replace the addressed lane with the low byte or halfword of req_store_data, and write the full word back.
- FSM states: IDLE, RD, CAPTURE, MERGE, WR, RESP, ERR.
  - IDLE: req_ready=1. When req_valid=1, latch the address, funct3, type and store data, then go to ERR if the request is an error, WR if it is SW, and RD otherwise.
  - RD: mem_read_enable=1. Go to CAPTURE for a load, MERGE for a store.
  - CAPTURE: extract the loaded value into resp_load_data. Go to RESP.
  - MERGE: build the merged word into the write buffer. Go to WR.
  - WR: mem_write_enable=1, mem_write_data = write buffer (SW: latched store data). Go to RESP.
  - RESP: resp_valid=1, resp_error=0. Go to IDLE.
  - ERR: resp_valid=1, resp_error=1. Go to IDLE. resp_load_data is unchanged.
- req_ready=0 in every state except IDLE. req_valid asserted in other states is ignored, not queued.
- mem_read_enable and mem_write_enable are never asserted in the same cycle.

## Timing
- Cycle 0 is the acceptance cycle. Latency to resp_valid:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Load: 3 cycles.
  - SB/SH: 4 cycles.
- Back-to-back requests: a new request can be accepted in the cycle after resp_valid, when the unit is back in IDLE.
- mem_addr is driven from the latched address in every non-IDLE state and is 0 in IDLE.
- On reset assertion, asynchronously: state=IDLE, req_ready=1, and all other outputs (resp_valid, resp_error, resp_load_data, mem_addr, mem_read_enable, mem_write_enable, mem_write_data) = 0.
- Reset mid-operation aborts the access. A write is lost unless the WR cycle completed before reset.

## Structure
- Shared package processor_pkg holds:
  - Funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - lsu_state_t enum.
- Sub-module lsu_byte_lane (combinational) holds the load extract/extend and the store merge logic, given funct3, addr[1:0] and word inputs.

## Test plan
- Memory word 3 = 0x8899AABB; LB, base 0x0C, offset 1 -> RD in cycle 1, resp_valid in cycle 3, resp_load_data 0xFFFFFFAA, resp_error 0.
- Same word; LHU at 0x0E -> 0x00008899. LH at 0x0E -> 0xFFFF8899. LW at 0x0C -> 0x8899AABB.
- SB with data 0x12345677 at 0x0F -> read word 3, then write 0x7799AABB in cycle 3, resp_valid in cycle 4.
- SW 0xDEADBEEF, base 0x10, offset −4 -> mem_write_enable in cycle 1 with mem_addr=3, resp_valid in cycle 2, no read.
- LW at 0x0E, SH at 0x0D, funct3=3 load, and is_load=is_store=1 -> each gives resp_valid=1 with resp_error=1 in cycle 1, no mem strobes, resp_load_data unchanged.
- reset low during MERGE of an SH -> immediately IDLE with all outputs 0, no write. After release, a new LW completes normally.
